// File: rtl/zone_scan_ctrl_pkg.sv
// rtl/zone_scan_ctrl_pkg.sv - shared encodings and sizing helpers for the zone scan controller
package zone_scan_ctrl_pkg;

   localparam int ZONE_W    = 4;
   localparam int NUM_ZONES = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_NEXT   = 3'd3,
      ST_ALARM  = 3'd4
   } scan_state_e;

   // Bits needed to hold 0..trip_count, i.e. ceil(log2(trip_count+1)).
   function automatic int cnt_width(input int trip_count);
      int w;
      w = 1;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < trip_count + 1) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/zone_trip_bank.sv
// rtl/zone_trip_bank.sv - per-zone saturating consecutive-trip counters
module zone_trip_bank
   import zone_scan_ctrl_pkg::*;
#(
   parameter int TRIP_COUNT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ZONE_W-1:0] idx,
   input  logic              inc,
   input  logic              clr,
   input  logic              clr_all,
   output logic              hit
);

   localparam int            CW       = cnt_width(TRIP_COUNT);
   localparam logic [CW-1:0] TRIP_MAX = CW'(TRIP_COUNT);

   logic [CW-1:0] cnt_q [NUM_ZONES];
   logic [CW-1:0] cnt_d [NUM_ZONES];
   logic [CW:0]   cnt_plus;

   // Next counter values: clear-all wins, then per-index clear, then saturating increment.
   always_comb begin
      for (int i = 0; i < NUM_ZONES; i++) begin
         cnt_d[i] = cnt_q[i];
         if (clr_all) begin
            cnt_d[i] = '0;
         end else if (idx == ZONE_W'(i)) begin
            if (clr) begin
               cnt_d[i] = '0;
            end else if (inc && (cnt_q[i] != TRIP_MAX)) begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // Flag that this increment brings the selected zone to the trip threshold.
   always_comb begin
      cnt_plus = {1'b0, cnt_q[idx]} + {{CW{1'b0}}, 1'b1};
      hit      = inc && (cnt_plus >= {1'b0, TRIP_MAX});
   end

   // Counter storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ZONES; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_ZONES; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

endmodule

// File: rtl/zone_scan_ctrl.sv
// rtl/zone_scan_ctrl.sv - 16-zone demux scan controller with consecutive-trip alarm
module zone_scan_ctrl
   import zone_scan_ctrl_pkg::*;
#(
   parameter int DWELL      = 4,
   parameter int TRIP_COUNT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        arm,
   input  logic [15:0] zone_mask,
   input  logic        sense,
   input  logic        alarm_ack,
   output logic [3:0]  demux_sel,
   output logic        demux_din,
   output logic        alarm,
   output logic [3:0]  alarm_zone,
   output logic [15:0] trip_map,
   output logic        scan_done
);

   // SETTLE lasts DWELL-1 cycles: dwell counter runs 0..DWELL-2.
   localparam logic [3:0] DWELL_LAST = 4'(DWELL - 2);

   scan_state_e state_q, state_d;
   logic [3:0]  dwell_q, dwell_d;
   logic [3:0]  sel_q, sel_d;
   logic        din_q, din_d;
   logic        alarm_q, alarm_d;
   logic [3:0]  alarm_zone_q, alarm_zone_d;
   logic [15:0] trip_map_q, trip_map_d;
   logic        scan_done_q, scan_done_d;

   logic        cnt_inc;
   logic        cnt_clr;
   logic        cnt_clr_all;
   logic        cnt_hit;
   logic        zone_live;

   zone_trip_bank #(
      .TRIP_COUNT (TRIP_COUNT)
   ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .idx     (sel_q),
      .inc     (cnt_inc),
      .clr     (cnt_clr),
      .clr_all (cnt_clr_all),
      .hit     (cnt_hit)
   );

   assign zone_live = ~zone_mask[sel_q];

   // Next-state and registered-output logic; outputs follow the current state by one cycle.
   always_comb begin
      state_d      = state_q;
      dwell_d      = dwell_q;
      sel_d        = sel_q;
      din_d        = 1'b0;
      alarm_d      = 1'b0;
      alarm_zone_d = alarm_zone_q;
      trip_map_d   = trip_map_q;
      scan_done_d  = 1'b0;
      cnt_inc      = 1'b0;
      cnt_clr      = 1'b0;
      cnt_clr_all  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            sel_d   = '0;
            dwell_d = '0;
            if (arm) begin
               state_d     = ST_SETTLE;
               trip_map_d  = '0;
               cnt_clr_all = 1'b1;
            end
         end
         ST_SETTLE: begin
            din_d = zone_live;
            if (dwell_q == DWELL_LAST) begin
               dwell_d = '0;
               state_d = ST_SAMPLE;
            end else begin
               dwell_d = dwell_q + 4'd1;
            end
         end
         ST_SAMPLE: begin
            din_d = zone_live;
            if (zone_live) begin
               cnt_inc = sense;
               cnt_clr = ~sense;
            end
            state_d = cnt_hit ? ST_ALARM : ST_NEXT;
         end
         ST_NEXT: begin
            sel_d       = sel_q + 4'd1;
            scan_done_d = (sel_q == 4'd15);
            state_d     = ST_SETTLE;
         end
         ST_ALARM: begin
            alarm_d           = 1'b1;
            alarm_zone_d      = sel_q;
            trip_map_d[sel_q] = 1'b1;
            if (alarm_ack) begin
               cnt_clr = 1'b1;
               state_d = ST_NEXT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Disarm overrides everything except the sticky trip map.
      if (!arm) begin
         state_d     = ST_IDLE;
         sel_d       = '0;
         dwell_d     = '0;
         din_d       = 1'b0;
         alarm_d     = 1'b0;
         scan_done_d = 1'b0;
         cnt_inc     = 1'b0;
         cnt_clr     = 1'b0;
         cnt_clr_all = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         dwell_q      <= '0;
         sel_q        <= '0;
         din_q        <= 1'b0;
         alarm_q      <= 1'b0;
         alarm_zone_q <= '0;
         trip_map_q   <= '0;
         scan_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         dwell_q      <= dwell_d;
         sel_q        <= sel_d;
         din_q        <= din_d;
         alarm_q      <= alarm_d;
         alarm_zone_q <= alarm_zone_d;
         trip_map_q   <= trip_map_d;
         scan_done_q  <= scan_done_d;
      end
   end

   assign demux_sel  = sel_q;
   assign demux_din  = din_q;
   assign alarm      = alarm_q;
   assign alarm_zone = alarm_zone_q;
   assign trip_map   = trip_map_q;
   assign scan_done  = scan_done_q;

endmodule
